// File: rtl/pipe_enq_arbiter.sv
// ---------------------------------------------------------------------------
// pipe_enq_arbiter
//
// Round-robin arbiter that merges three requester enqueue ports into a single
// downstream pipe through a one-entry output register. A requester is offered
// RDY when the register can take a message this cycle and no requester ahead
// of it in the current priority order is strobing. Messages whose length is
// outside 1..4 words are accepted but dropped and counted.
//
// Ports
//   CLK                 clock, all state updates on the rising edge
//   RST                 synchronous active-high reset
//   reqN_enq__ENA       requester N enqueue strobe (N = 0..2)
//   reqN_enq_v          requester N payload (DATA_W bits)
//   reqN_enq_length     requester N payload length in 32-bit words
//   reqN_enq__RDY       requester N may enqueue this cycle
//   pipe_enq__ENA       downstream enqueue strobe (output register valid)
//   pipe_enq_v          downstream payload, zero when not valid
//   pipe_enq_length     downstream length, zero when not valid
//   pipe_enq__RDY       downstream can accept this cycle
//   sent_count          messages delivered downstream (wrapping)
//   drop_count          messages dropped for illegal length (saturating)
//   proto_err           sticky: a requester strobed while its RDY was low
//
// NREQ documents the requester count; the port list is written out for
// exactly three requesters.
// ---------------------------------------------------------------------------
module pipe_enq_arbiter #(
  parameter int NREQ   = 3,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,

  input  logic              req0_enq__ENA,
  input  logic [DATA_W-1:0] req0_enq_v,
  input  logic [LEN_W-1:0]  req0_enq_length,
  output logic              req0_enq__RDY,

  input  logic              req1_enq__ENA,
  input  logic [DATA_W-1:0] req1_enq_v,
  input  logic [LEN_W-1:0]  req1_enq_length,
  output logic              req1_enq__RDY,

  input  logic              req2_enq__ENA,
  input  logic [DATA_W-1:0] req2_enq_v,
  input  logic [LEN_W-1:0]  req2_enq_length,
  output logic              req2_enq__RDY,

  output logic              pipe_enq__ENA,
  output logic [DATA_W-1:0] pipe_enq_v,
  output logic [LEN_W-1:0]  pipe_enq_length,
  input  logic              pipe_enq__RDY,

  output logic [31:0]       sent_count,
  output logic [7:0]        drop_count,
  output logic              proto_err
);

  // -------------------------------------------------------------------------
  // Helper functions
  // -------------------------------------------------------------------------

  // Requester index that sits `off` places after `base` in priority order.
  function automatic logic [1:0] wrap_idx(input logic [1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NREQ) s = s - NREQ;
    return 2'(s);
  endfunction

  // Pointer value after an accept from requester n.
  function automatic logic [1:0] next_ptr(input logic [1:0] n);
    return (n == 2'd2) ? 2'd0 : n + 2'd1;
  endfunction

  // Only 1..4 word messages are forwarded downstream.
  function automatic logic len_legal(input logic [LEN_W-1:0] len);
    return (len != '0) && (len <= LEN_W'(4));
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Stage p0: requester inputs, arbitration and accept selection
  // -------------------------------------------------------------------------
  logic [NREQ-1:0]   ena_p0;
  logic [NREQ-1:0]   rdy_p0;
  logic [NREQ-1:0]   acc_p0;
  logic [DATA_W-1:0] v_p0   [NREQ];
  logic [LEN_W-1:0]  len_p0 [NREQ];

  logic [1:0]        ptr_q;
  logic              vld_p1;
  logic [DATA_W-1:0] v_p1;
  logic [LEN_W-1:0]  len_p1;

  logic              free_p0;
  logic              drain_p0;
  logic              any_acc_p0;
  logic [1:0]        sel_idx_p0;
  logic [DATA_W-1:0] sel_v_p0;
  logic [LEN_W-1:0]  sel_len_p0;
  logic              load_p0;
  logic              drop_p0;
  logic              viol_p0;

  assign ena_p0    = {req2_enq__ENA, req1_enq__ENA, req0_enq__ENA};
  assign v_p0[0]   = req0_enq_v;
  assign v_p0[1]   = req1_enq_v;
  assign v_p0[2]   = req2_enq_v;
  assign len_p0[0] = req0_enq_length;
  assign len_p0[1] = req1_enq_length;
  assign len_p0[2] = req2_enq_length;

  // The register can take a new message if it is empty or being drained now.
  assign free_p0  = !vld_p1 || pipe_enq__RDY;
  assign drain_p0 = pipe_enq__ENA && pipe_enq__RDY;

  // Walk the priority order from ptr. Each requester's RDY is decided before
  // its own ENA is folded into `blocked`, so RDY never depends on its own ENA.
  always_comb begin
    logic       blocked;
    logic [1:0] idx;
    rdy_p0  = '0;
    blocked = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx         = wrap_idx(ptr_q, k);
      rdy_p0[idx] = free_p0 && !RST && !blocked;
      blocked     = blocked || ena_p0[idx];
    end
  end

  assign acc_p0  = ena_p0 & rdy_p0;
  assign viol_p0 = |(ena_p0 & ~rdy_p0);

  // At most one bit of acc_p0 can be set: any accepted requester has no
  // strobing requester ahead of it, and everyone behind it sees RDY low.
  always_comb begin
    any_acc_p0 = 1'b0;
    sel_idx_p0 = 2'd0;
    sel_v_p0   = '0;
    sel_len_p0 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (acc_p0[i]) begin
        any_acc_p0 = 1'b1;
        sel_idx_p0 = 2'(i);
        sel_v_p0   = v_p0[i];
        sel_len_p0 = len_p0[i];
      end
    end
  end

  assign load_p0 = any_acc_p0 && len_legal(sel_len_p0);
  assign drop_p0 = any_acc_p0 && !len_legal(sel_len_p0);

  assign req0_enq__RDY = rdy_p0[0];
  assign req1_enq__RDY = rdy_p0[1];
  assign req2_enq__RDY = rdy_p0[2];

  // -------------------------------------------------------------------------
  // Stage p1: output register and counters
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      vld_p1     <= 1'b0;
      ptr_q      <= 2'd0;
      sent_count <= '0;
      drop_count <= '0;
      proto_err  <= 1'b0;
    end else begin
      // A legal refill wins over a drain so back-to-back messages stream.
      if (load_p0)       vld_p1 <= 1'b1;
      else if (drain_p0) vld_p1 <= 1'b0;

      if (any_acc_p0) ptr_q      <= next_ptr(sel_idx_p0);
      if (drain_p0)   sent_count <= sent_count + 32'd1;
      if (drop_p0)    drop_count <= sat_inc8(drop_count);
      if (viol_p0)    proto_err  <= 1'b1;
    end
  end

  // Payload is qualified by vld_p1 and gated at the output, so it needs no
  // reset. It only changes on a legal accept, which requires free_p0, so it
  // is held stable under backpressure.
  always_ff @(posedge CLK) begin
    if (load_p0) begin
      v_p1   <= sel_v_p0;
      len_p1 <= sel_len_p0;
    end
  end

  assign pipe_enq__ENA   = vld_p1 && !RST;
  assign pipe_enq_v      = pipe_enq__ENA ? v_p1   : '0;
  assign pipe_enq_length = pipe_enq__ENA ? len_p1 : '0;

endmodule

// File: tb/tb_pipe_enq_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pipe_enq_arbiter
//
// Directed bench for pipe_enq_arbiter. Inputs change 1 ns after the rising
// edge; outputs are sampled a further 1 ns later, well away from either edge.
// ---------------------------------------------------------------------------
module tb_pipe_enq_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   ena;
  logic [127:0] v   [3];
  logic [15:0]  len [3];
  logic [2:0]   rdy;
  logic         p_ena;
  logic [127:0] p_v;
  logic [15:0]  p_len;
  logic         p_rdy;
  logic [31:0]  sent;
  logic [7:0]   drop;
  logic         perr;

  int vec_cnt = 0;
  int miscmp  = 0;

  always #5 clk = ~clk;

  pipe_enq_arbiter dut (
    .CLK             (clk),
    .RST             (rst),
    .req0_enq__ENA   (ena[0]),
    .req0_enq_v      (v[0]),
    .req0_enq_length (len[0]),
    .req0_enq__RDY   (rdy[0]),
    .req1_enq__ENA   (ena[1]),
    .req1_enq_v      (v[1]),
    .req1_enq_length (len[1]),
    .req1_enq__RDY   (rdy[1]),
    .req2_enq__ENA   (ena[2]),
    .req2_enq_v      (v[2]),
    .req2_enq_length (len[2]),
    .req2_enq__RDY   (rdy[2]),
    .pipe_enq__ENA   (p_ena),
    .pipe_enq_v      (p_v),
    .pipe_enq_length (p_len),
    .pipe_enq__RDY   (p_rdy),
    .sent_count      (sent),
    .drop_count      (drop),
    .proto_err       (perr)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int n, input logic [127:0] val, input logic [15:0] l);
    ena    = 3'b000;
    ena[n] = 1'b1;
    v[n]   = val;
    len[n] = l;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ena = 3'b000;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    ena   = 3'b000;
    p_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      v[i]   = '0;
      len[i] = '0;
    end

    // ---- reset state, RDY forced low even with strobes present
    tick();
    tick();
    ena = 3'b111;
    #1;
    check("rst_rdy",  rdy,       3'b000);
    check("rst_pena", p_ena,     1'b0);
    check("rst_sent", sent,      0);
    check("rst_drop", drop,      0);
    check("rst_perr", perr,      1'b0);
    check("rst_ptr",  dut.ptr_q, 0);
    ena = 3'b000;
    tick();
    check("rst_perr_hold", perr, 1'b0);
    rst = 1'b0;
    #1;
    check("idle_rdy", rdy, 3'b111);

    // ---- single send from req1
    send(1, 128'h5, 16'd2);
    #1;
    check("s1_rdy", rdy, 3'b011);
    tick();
    ena = 3'b000;
    #1;
    check("s1_pena", p_ena,     1'b1);
    check("s1_plen", p_len,     16'd2);
    check("s1_pv",   p_v,       128'h5);
    check("s1_ptr",  dut.ptr_q, 2);
    check("s1_sent0", sent,     0);
    tick();
    check("s1_sent1", sent,  1);
    check("s1_idle",  p_ena, 1'b0);
    check("s1_pv0",   p_v,   0);

    // ---- contention: all three strobe every cycle, arbitration resumes at 0
    do_reset();
    check("c_ptr0", dut.ptr_q, 0);
    for (int i = 0; i < 3; i++) begin
      v[i]   = 128'h100 + 128'(i);
      len[i] = 16'(i + 1);
    end
    for (int k = 0; k < 6; k++) begin
      ena = 3'b111;
      #1;
      check("c_rdy", rdy, 3'b001 << (k % 3));
      tick();
      check("c_pena", p_ena, 1'b1);
      check("c_pv",   p_v,   128'h100 + 128'(k % 3));
      check("c_plen", p_len, 16'((k % 3) + 1));
    end
    ena = 3'b000;
    check("c_sent5", sent, 5);
    tick();
    check("c_sent6", sent,  6);
    check("c_idle",  p_ena, 1'b0);
    check("c_perr",  perr,  1'b1);

    // ---- backpressure then release with same-cycle refill
    do_reset();
    check("b_perr0", perr, 1'b0);
    send(0, 128'hAB, 16'd3);
    tick();
    ena   = 3'b000;
    p_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("b_rdy",  rdy,   3'b000);
      check("b_pena", p_ena, 1'b1);
      check("b_pv",   p_v,   128'hAB);
      check("b_plen", p_len, 16'd3);
      tick();
    end
    check("b_sent0", sent, 0);
    send(2, 128'hCD, 16'd4);
    p_rdy = 1'b1;
    #1;
    check("b_rdy_rel", rdy, 3'b110);
    tick();
    ena = 3'b000;
    #1;
    check("b_pv2",   p_v,   128'hCD);
    check("b_plen2", p_len, 16'd4);
    check("b_sent1", sent,  1);
    tick();
    check("b_sent2", sent,  2);
    check("b_idle",  p_ena, 1'b0);
    check("b_perr",  perr,  1'b0);

    // ---- illegal lengths: dropped, counted, saturating
    do_reset();
    send(2, 128'h0, 16'd5);
    #1;
    check("d_rdy2", rdy[2], 1'b1);
    tick();
    ena = 3'b000;
    check("d_pena", p_ena,     1'b0);
    check("d_cnt1", drop,      1);
    check("d_ptr0", dut.ptr_q, 0);
    send(0, 128'h7, 16'd0);
    tick();
    ena = 3'b000;
    check("d_cnt2", drop,      2);
    check("d_ptr1", dut.ptr_q, 1);
    check("d_pena0", p_ena,    1'b0);
    send(1, 128'h9, 16'hFFFF);
    repeat (260) tick();
    ena = 3'b000;
    check("d_sat",  drop,      255);
    check("d_ptr2", dut.ptr_q, 2);
    check("d_sent", sent,      0);
    // illegal accept while the register drains: register empties
    send(0, 128'h11, 16'd1);
    tick();
    send(1, 128'h22, 16'd6);
    #1;
    check("d_rdy1", rdy[1], 1'b1);
    tick();
    ena = 3'b000;
    check("d_drain_pena", p_ena,     1'b0);
    check("d_drain_sent", sent,      1);
    check("d_drain_sat",  drop,      255);
    check("d_drain_ptr",  dut.ptr_q, 2);

    // ---- protocol error is sticky until reset
    do_reset();
    v[0] = 128'h31; len[0] = 16'd1;
    v[1] = 128'h32; len[1] = 16'd1;
    ena  = 3'b011;
    #1;
    check("p_rdy", rdy, 3'b001);
    tick();
    ena = 3'b000;
    check("p_perr", perr, 1'b1);
    check("p_pv",   p_v,  128'h31);
    repeat (3) tick();
    check("p_sticky", perr, 1'b1);
    do_reset();
    check("p_clear", perr, 1'b0);

    // ---- reset mid-operation discards a held message
    send(0, 128'h41, 16'd2);
    tick();
    ena = 3'b000;
    tick();
    check("r_sent1", sent, 1);
    p_rdy = 1'b0;
    send(1, 128'h42, 16'd3);
    tick();
    ena = 3'b000;
    check("r_pena", p_ena, 1'b1);
    check("r_pv",   p_v,   128'h42);
    rst = 1'b1;
    #1;
    check("r_pena_rst", p_ena, 1'b0);
    check("r_rdy_rst",  rdy,   3'b000);
    tick();
    rst   = 1'b0;
    p_rdy = 1'b1;
    #1;
    check("r_pena_after", p_ena,     1'b0);
    check("r_sent0",      sent,      0);
    check("r_drop0",      drop,      0);
    check("r_ptr0",       dut.ptr_q, 0);
    check("r_pv0",        p_v,       0);
    tick();
    check("r_lost", sent, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule

// File: doc/pipe_enq_arbiter.md
PIPE_ENQ_ARBITER -- requirements
Module: pipe_enq_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, meaning number of requester ports (fixed at 3 for this revision).
REQ-002 SHALL have port CLK, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RST, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have ports reqN$enq__ENA, input, 1, per requester N=0..2, requester enqueue strobe.
REQ-005 SHALL have ports reqN$enq$v, input, 128, per requester, message payload.
REQ-006 SHALL have ports reqN$enq$length, input, 16, per requester, payload length in 32-bit words.
REQ-007 SHALL have ports reqN$enq__RDY, output, 1, per requester, enqueue accepted this cycle if ENA is high.
REQ-008 SHALL have port pipe$enq__ENA, output, 1, downstream enqueue strobe.
REQ-009 SHALL have port pipe$enq$v, output, 128, downstream payload.
REQ-010 SHALL have port pipe$enq$length, output, 16, downstream length.
REQ-011 SHALL have port pipe$enq__RDY, input, 1, downstream can accept.
REQ-012 SHALL have port sent_count, output, 32, messages delivered downstream.
REQ-013 SHALL have port drop_count, output, 8, messages rejected for illegal length.
REQ-014 SHALL have port proto_err, output, 1, sticky: a requester strobed ENA while its RDY was low.

Function
REQ-015 SHALL hold one message in an output register (valid, v, length); free = !valid | pipe$enq__RDY.
REQ-016 SHALL keep a round-robin pointer ptr (0..2); priority order ptr, ptr+1, ptr+2 (mod 3).
REQ-017 SHALL drive reqN$enq__RDY = free & no requester ahead of N in priority order has ENA high; RDY_N SHALL NOT depend on reqN$enq__ENA itself.
REQ-018 SHALL accept requester N in a cycle iff reqN$enq__ENA & reqN$enq__RDY; at most one accept per cycle.
REQ-019 SHALL, on accept with length 1..4, load v/length into the register and set valid the next cycle (one-cycle latency input to output).
REQ-020 SHALL, on accept with length 0 or >4, not load the register, increment drop_count (saturating at 255); valid becomes 0 if the register was drained that cycle.
REQ-021 SHALL, on any accept from N, set ptr to (N+1) mod 3 next cycle; ptr unchanged when no accept.
REQ-022 SHALL drive pipe$enq__ENA = valid, and pipe$enq$v / pipe$enq$length from the register when valid, all-zero when not valid.
REQ-023 SHALL clear valid on pipe$enq__ENA & pipe$enq__RDY unless a legal accept occurs in the same cycle (simultaneous drain and refill keeps valid=1 with new data, full throughput).
REQ-024 SHALL hold register contents stable while valid & !pipe$enq__RDY.
REQ-025 SHALL increment sent_count (wrapping at 2^32) on each pipe$enq__ENA & pipe$enq__RDY.
REQ-026 SHALL set proto_err when any reqN$enq__ENA is high while reqN$enq__RDY is low; such strobes are otherwise ignored.

Reset
REQ-027 SHALL, while RST high at a clock edge, set valid=0, ptr=0, sent_count=0, drop_count=0, proto_err=0; a pending message is discarded.
REQ-028 SHALL drive all reqN$enq__RDY low and pipe$enq__ENA low while RST is high.
REQ-029 SHALL resume arbitration from ptr=0 on the first cycle after RST deasserts.

Verification
REQ-030 Single send: req1 ENA, length=2, v=0x...0005, pipe RDY=1 -> next cycle pipe$enq__ENA=1, length=2, same v; sent_count=1; ptr=2.
REQ-031 Contention: req0,req1,req2 ENA every cycle, pipe RDY=1, ptr=0 -> delivered order 0,1,2,0,1,2 back-to-back, one per cycle, sent_count=6 after 6 deliveries.
REQ-032 Backpressure: register valid, pipe RDY=0 for 5 cycles -> all reqN RDY=0, output v/length stable; RDY=1 -> message delivered, refill same cycle.
REQ-033 Illegal length: req2 ENA length=5 -> accepted (RDY=1), no pipe ENA, drop_count=1, ptr=0; 256 such drops -> drop_count=255.
REQ-034 Protocol error: req1 ENA while req0 ENA and ptr=0 -> req1 RDY=0, proto_err=1 and stays 1 until RST.
REQ-035 Reset mid-operation: register valid with pipe RDY=0, assert RST one cycle -> pipe$enq__ENA=0, counters 0, ptr=0, message lost.
